video_stream_switch: RTL and testbench
======================================

Name: video_stream_switch

Overview:
N-input, frame-aligned AXI4-Stream video switch with a registered output. It supersedes the static 2:1 combinational video select in the camera video path. A source change is applied only on video boundaries: the current line is finished, then output resumes at the next start-of-frame (tuser) of the new source. Unselected sources are drained or stalled per parameter.

Parameters:
DATA_W, 24, pixel data width (RGB888)
NUM_IN, 4, number of input streams (2..16)
SEL_W, 2, width of sel; must be >= clog2(NUM_IN)
DROP_UNSELECTED, 1, 1: unselected inputs held tready=1 (beats discarded); 0: unselected tready=0 (stalled)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
sel  in  SEL_W  requested source index, sampled every cycle
s_axis_video_tdata  in  NUM_IN*DATA_W  input data, input i at bits [i*DATA_W +: DATA_W]
s_axis_video_tvalid  in  NUM_IN  per-input valid
s_axis_video_tready  out  NUM_IN  per-input ready
s_axis_video_tlast  in  NUM_IN  per-input end-of-line
s_axis_video_tuser  in  NUM_IN  per-input start-of-frame
m_axis_video_tdata  out  DATA_W  output data (registered)
m_axis_video_tvalid  out  1  output valid (registered)
m_axis_video_tready  in  1  downstream ready
m_axis_video_tlast  out  1  output end-of-line
m_axis_video_tuser  out  1  output start-of-frame
sel_active  out  SEL_W  source currently routed or being synced
locked  out  1  1 in LOCKED or DRAIN
switch_done  out  1  one-cycle pulse when the SOF beat of a new source is accepted

Behaviour:
- Reset (async, rstn=0): state=SYNC, sel_active=0, m_axis_video_tvalid/tdata/tlast/tuser=0, locked=0, switch_done=0, all s_axis_video_tready=0. Output valid drops immediately, even mid-frame. The first frame after reset starts at a SOF.
- Output register: out_free = !m_axis_video_tvalid || m_axis_video_tready. An accepted input beat loads the register on the next edge, giving 1 cycle latency. tvalid clears when the register drains and no beat is accepted. Full throughput is 1 beat/clk. tdata/tlast/tuser are held stable while tvalid=1 and tready=0.
- Let A = sel_active. Accept = s_tvalid[A] && s_tready[A].
- State SYNC:
  - s_tready[A] = s_tuser[A] ? out_free : 1.
  - Non-SOF beats on A are discarded.
  - An accepted SOF beat is loaded to the output, switch_done=1, next state is LOCKED.
  - If a valid sel (< NUM_IN) differs from A, A takes sel immediately and SYNC continues.
- State LOCKED:
  - s_tready[A] = out_free. Every accepted beat is forwarded.
  - If a valid sel differs from A, latch req=sel and go to DRAIN.
- State DRAIN:
  - Forwarding continues as in LOCKED.
  - When a beat with tlast=1 is accepted: A=req, next state is SYNC.
  - If sel returns to A before that, go back to LOCKED (switch cancelled).
  - If sel changes to another valid value, req is updated.
- Out-of-range sel (>= NUM_IN) is ignored in all states; current behaviour is kept.
- Unselected inputs (i != A): s_tready[i] = DROP_UNSELECTED.
- tuser on A in LOCKED (a new frame without switching) is forwarded normally. A missing tlast leaves DRAIN pending until tlast arrives.
- Simultaneous events:
  - A sel change in the same cycle as the tlast acceptance in LOCKED enters DRAIN; the switch waits for the next tlast.
  - In DRAIN, a tlast accept and a sel update in the same cycle use the new sel as the target.
- switch_done pulses exactly once per completed switch, including the first SOF after reset.

Test Plan:
- Reset, sel=0; input 0 sends 3 non-SOF beats then a SOF frame of 2 lines x 4 px -> the 3 beats are dropped, output is exactly 8 beats starting with tuser=1, tlast on beats 4 and 8, switch_done pulses once, 1-cycle latency.
- LOCKED on 0 with continuous valid, m_tready=1 -> one beat per clock, no bubbles; tdata matches the input with 1 cycle delay.
- sel 0->2 mid-line (pixel 2 of 4) -> the rest of the line from input 0 is output through tlast; input 2 non-SOF beats are discarded; output resumes at input 2's SOF with tuser=1; sel_active=2.
- Backpressure: m_tready toggled 1010..., plus a 3-cycle stall -> no beat lost or duplicated; output fields stable while stalled; s_tready[A]=0 only when the register is full and not draining.
- DROP_UNSELECTED=0 vs 1 with inputs 1 and 3 valid while sel=0 -> their s_tready stays 0 in the first case and 1 in the second.
- Edge cases: sel=5 with NUM_IN=4 (ignored); sel 0->1->0 before tlast (cancelled, no gap); rstn asserted mid-line (m_tvalid=0 immediately, resync on next SOF).

Source files
------------

// File: rtl/video_stream_switch_if.sv
// AXI4-Stream video bundle, LANES parallel streams sharing one bus.
// Lane i's pixel data is tdata[i*DATA_W +: DATA_W].
interface video_stream_switch_if #(
    parameter int DATA_W = 24,
    parameter int LANES  = 1
);
    logic [LANES*DATA_W-1:0] tdata;
    logic [LANES-1:0]        tvalid;
    logic [LANES-1:0]        tready;
    logic [LANES-1:0]        tlast;
    logic [LANES-1:0]        tuser;

    modport master (output tdata, tvalid, tlast, tuser, input  tready);
    modport slave  (input  tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/video_stream_switch.sv
// N:1 frame-aligned AXI4-Stream video switch with a registered output.
// A source change is deferred until the current line ends (tlast). Output
// then resumes at the next start-of-frame (tuser) of the new source.
module video_stream_switch #(
    parameter int DATA_W          = 24,
    parameter int NUM_IN          = 4,
    parameter int SEL_W           = 2,
    parameter int DROP_UNSELECTED = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [SEL_W-1:0]      sel,
    video_stream_switch_if.slave  s_axis_video,
    video_stream_switch_if.master m_axis_video,
    output logic [SEL_W-1:0]      sel_active,
    output logic                  locked,
    output logic                  switch_done
);
    typedef enum logic [1:0] {SYNC, LOCKED, DRAIN} state_t;

    state_t              state, state_nx;
    logic [SEL_W-1:0]    act, act_nx, req, req_nx;
    logic                done_nx;
    logic                sel_ok, sel_new, out_free;
    logic                a_vld, a_last, a_user, a_rdy, acc, fwd;
    logic [DATA_W-1:0]   a_data;
    logic [NUM_IN-1:0]   rdy;

    // Out-of-range requests are ignored entirely.
    assign sel_ok   = 32'(sel) < NUM_IN;
    assign sel_new  = sel_ok && (sel != act);
    assign out_free = !m_axis_video.tvalid[0] || m_axis_video.tready[0];
    assign acc      = a_vld && a_rdy;
    // In SYNC, only the SOF beat reaches the output; earlier beats are dropped.
    assign fwd      = acc && ((state != SYNC) || a_user);
    assign sel_active = act;

    // Pick out the active input's fields.
    always_comb begin
        a_vld  = 1'b0;
        a_last = 1'b0;
        a_user = 1'b0;
        a_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (act == SEL_W'(i)) begin
                a_vld  = s_axis_video.tvalid[i];
                a_last = s_axis_video.tlast[i];
                a_user = s_axis_video.tuser[i];
                a_data = s_axis_video.tdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // State, active source, pending request and switch pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= SYNC;
            act         <= '0;
            req         <= '0;
            switch_done <= 1'b0;
        end else begin
            state       <= state_nx;
            act         <= act_nx;
            req         <= req_nx;
            switch_done <= done_nx;
        end
    end

    // Next-state: retarget freely in SYNC, defer switches to the line end.
    always_comb begin
        state_nx = state;
        act_nx   = act;
        req_nx   = req;
        done_nx  = 1'b0;
        case (state)
            SYNC: begin
                if (acc && a_user) begin
                    state_nx = LOCKED;
                    done_nx  = 1'b1;
                end else if (sel_new) begin
                    act_nx = sel;
                end
            end
            LOCKED: begin
                if (sel_new) begin
                    req_nx   = sel;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (sel_ok && sel == act) begin
                    state_nx = LOCKED;
                end else begin
                    if (sel_new) req_nx = sel;
                    // The newest request wins, even one arriving with tlast.
                    if (acc && a_last) begin
                        act_nx   = req_nx;
                        state_nx = SYNC;
                    end
                end
            end
            default: state_nx = SYNC;
        endcase
    end

    // Outputs: per-input ready and lock status.
    always_comb begin
        if (state == SYNC && !a_user) a_rdy = 1'b1;
        else                          a_rdy = out_free;
        a_rdy = a_rdy && rstn;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!rstn)                  rdy[i] = 1'b0;
            else if (act == SEL_W'(i))  rdy[i] = a_rdy;
            else                        rdy[i] = (DROP_UNSELECTED != 0);
        end
        s_axis_video.tready = rdy;
        locked = (state != SYNC);
    end

    // Output register: loads on a forwarded beat, empties when drained.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_axis_video.tvalid <= '0;
            m_axis_video.tdata  <= '0;
            m_axis_video.tlast  <= '0;
            m_axis_video.tuser  <= '0;
        end else if (fwd) begin
            m_axis_video.tvalid <= 1'b1;
            m_axis_video.tdata  <= a_data;
            m_axis_video.tlast  <= a_last;
            m_axis_video.tuser  <= a_user;
        end else if (m_axis_video.tready[0]) begin
            m_axis_video.tvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_video_stream_switch.sv
// Self-checking bench for video_stream_switch: per-source beat queues drive
// the inputs; the expected output is the list of beats that the switching
// rules say must survive, compared in order against the captured output.
module tb_video_stream_switch;
    localparam int DW = 24;
    localparam int NI = 4;
    localparam int SW = 3;
    typedef logic [DW+2:0] beat_t;   // {fwd, user, last, data}

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [SW-1:0] sel = '0;
    logic [SW-1:0] sel_active, sel_active0;
    logic locked, locked0, switch_done, switch_done0;

    video_stream_switch_if #(.DATA_W(DW), .LANES(NI)) sif ();
    video_stream_switch_if #(.DATA_W(DW), .LANES(1))  mif ();
    video_stream_switch_if #(.DATA_W(DW), .LANES(NI)) sif0 ();
    video_stream_switch_if #(.DATA_W(DW), .LANES(1))  mif0 ();

    always #5 clk = ~clk;

    video_stream_switch #(.DATA_W(DW), .NUM_IN(NI), .SEL_W(SW), .DROP_UNSELECTED(1)) dut (
        .clk(clk), .rstn(rstn), .sel(sel), .s_axis_video(sif), .m_axis_video(mif),
        .sel_active(sel_active), .locked(locked), .switch_done(switch_done));

    // Stalling variant sees the same inputs; only its ready behaviour is checked.
    video_stream_switch #(.DATA_W(DW), .NUM_IN(NI), .SEL_W(SW), .DROP_UNSELECTED(0)) dut0 (
        .clk(clk), .rstn(rstn), .sel(sel), .s_axis_video(sif0), .m_axis_video(mif0),
        .sel_active(sel_active0), .locked(locked0), .switch_done(switch_done0));

    assign sif0.tdata  = sif.tdata;
    assign sif0.tvalid = sif.tvalid;
    assign sif0.tlast  = sif.tlast;
    assign sif0.tuser  = sif.tuser;
    assign mif0.tready = mif.tready;

    int n_cmp = 0;
    int n_bad = 0;
    beat_t q[NI][$];
    beat_t exp_q[$];
    beat_t got_q[$];
    logic [NI-1:0] vld = '0;
    int nacc[NI];
    int vld_pct = 100;
    int rdy_mode = 0;
    int stall = 0;
    int done_cnt = 0;
    int rdy_src = 0;
    int base;
    bit chk_nobub = 0;
    bit chk_rdy = 0;
    logic tog = 1'b0;
    logic prev_fwd = 1'b0;
    logic prev_stall = 1'b0;
    beat_t prev_beat = '0;
    logic [DW+1:0] prev_out = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A beat marked fwd must appear at the output, in order.
    task automatic push_beat(input int s, input bit fwd, input bit user, input bit last);
        beat_t b;
        b = {fwd, user, last, 4'(s), 20'($urandom)};
        q[s].push_back(b);
        if (fwd) exp_q.push_back(b);
    endtask

    task automatic frame(input int s, input int lines, input int px, input bit sof, input bit fwd);
        for (int l = 0; l < lines; l++)
            for (int p = 0; p < px; p++)
                push_beat(s, fwd, sof && l == 0 && p == 0, p == px - 1);
    endtask

    task automatic junk(input int s, input int n);
        for (int k = 0; k < n; k++) push_beat(s, 1'b0, 1'b0, $urandom_range(3) == 0);
    endtask

    // One clock: drive at the falling edge, sample 1 time unit later.
    task automatic step();
        beat_t hd;
        logic [DW+1:0] cur;
        logic [NI-1:0] acc;
        for (int i = 0; i < NI; i++) begin
            if (!vld[i] && q[i].size() > 0 && $urandom_range(99) < vld_pct) vld[i] = 1'b1;
            hd = vld[i] ? q[i][0] : '0;
            sif.tvalid[i] = vld[i];
            sif.tuser[i]  = hd[DW+1];
            sif.tlast[i]  = hd[DW];
            sif.tdata[i*DW +: DW] = hd[DW-1:0];
        end
        if (stall > 0) begin
            mif.tready = 1'b0;
            stall--;
        end else begin
            case (rdy_mode)
                0: mif.tready = 1'b1;
                1: begin tog = ~tog; mif.tready = tog; end
                default: mif.tready = ($urandom_range(3) != 0);
            endcase
        end
        #1;
        cur = {mif.tuser[0], mif.tlast[0], mif.tdata};
        if (prev_fwd) begin
            chk("latency_vld", mif.tvalid, 1'b1);
            chk("latency_beat", cur, prev_beat[DW+1:0]);
        end
        if (prev_stall) chk("stall_hold", {mif.tvalid, cur}, {1'b1, prev_out});
        if (chk_rdy) chk("s_tready_A", sif.tready[rdy_src], !mif.tvalid[0] || mif.tready[0]);
        if (switch_done) begin
            done_cnt++;
            chk("done_at_sof", {mif.tvalid, mif.tuser}, 2'b11);
        end
        if (mif.tvalid[0] && mif.tready[0]) got_q.push_back({1'b1, cur});
        prev_stall = mif.tvalid[0] && !mif.tready[0];
        prev_out = cur;
        prev_fwd = 1'b0;
        for (int i = 0; i < NI; i++) begin
            acc[i] = vld[i] && sif.tready[i];
            if (acc[i] && q[i][0][DW+2]) begin
                prev_fwd = 1'b1;
                prev_beat = q[i][0];
            end
        end
        if (chk_nobub && q[rdy_src].size() > 0) chk("no_bubble", acc[rdy_src], 1'b1);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            if (acc[i]) begin
                void'(q[i].pop_front());
                vld[i] = 1'b0;
                nacc[i]++;
            end
        end
    endtask

    function automatic bit busy();
        busy = mif.tvalid[0];
        for (int i = 0; i < NI; i++) if (q[i].size() > 0) busy = 1'b1;
    endfunction

    task automatic run_idle(input int max);
        int n = 0;
        while (busy() && n < max) begin
            step();
            n++;
        end
        chk("idle_timeout", n < max, 1'b1);
    endtask

    task automatic wait_acc(input int s, input int target, input int max);
        int n = 0;
        while (nacc[s] < target && n < max) begin
            step();
            n++;
        end
        chk("acc_timeout", n < max, 1'b1);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            chk({tag, "_beat"}, got_q[k], exp_q[k]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) nacc[i] = 0;
        // Reset: everything quiet, even with valid SOF presented on all inputs.
        sif.tvalid = '1;
        sif.tuser  = '1;
        sif.tlast  = '0;
        sif.tdata  = '0;
        mif.tready = 1'b1;
        #2;
        chk("rst_m_tvalid", mif.tvalid, 1'b0);
        chk("rst_m_tdata", mif.tdata, '0);
        chk("rst_m_tlast", mif.tlast, 1'b0);
        chk("rst_m_tuser", mif.tuser, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_switch_done", switch_done, 1'b0);
        chk("rst_sel_active", sel_active, 0);
        chk("rst_s_tready", sif.tready, '0);
        chk("rst_s_tready_stall", sif0.tready, '0);
        chk("rst_m_tvalid_stall", mif0.tvalid, 1'b0);
        sif.tvalid = '0;
        sif.tuser  = '0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // First frame after reset: leading non-SOF beats are dropped.
        junk(0, 3);
        frame(0, 2, 4, 1'b1, 1'b1);
        run_idle(200);
        compare("first_frame");
        chk("first_done", done_cnt, 1);
        chk("first_locked", locked, 1'b1);
        chk("first_sel_active", sel_active, 0);

        // Full throughput while locked; a new SOF passes without a switch pulse.
        chk_nobub = 1'b1;
        rdy_src = 0;
        frame(0, 3, 5, 1'b1, 1'b1);
        run_idle(200);
        chk_nobub = 1'b0;
        compare("throughput");
        chk("throughput_done", done_cnt, 1);

        // Switch 0 -> 2 mid-line: line 0 completes, input 2 joins at its SOF.
        vld_pct = 70;
        rdy_mode = 2;
        frame(0, 1, 4, 1'b0, 1'b1);
        base = nacc[0];
        wait_acc(0, base + 2, 100);
        sel = 3'd2;
        run_idle(200);
        chk("switch_sel_active", sel_active, 2);
        chk("switch_syncing", locked, 1'b0);
        junk(2, 3);
        frame(2, 1, 4, 1'b1, 1'b1);
        run_idle(300);
        compare("switch");
        chk("switch_sel_active2", sel_active, 2);
        chk("switch_done_cnt", done_cnt, 2);

        // Backpressure: alternating ready plus a 3-cycle stall.
        vld_pct = 100;
        rdy_mode = 1;
        chk_rdy = 1'b1;
        rdy_src = 2;
        frame(2, 2, 6, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) step();
        stall = 3;
        run_idle(300);
        chk_rdy = 1'b0;
        compare("backpressure");

        // Unselected inputs: drained by one variant, stalled by the other.
        rdy_mode = 0;
        for (int k = 0; k < 2; k++) begin
            sif.tvalid = 4'b1010;
            #1;
            chk("drop_rdy1", sif.tready[1], 1'b1);
            chk("drop_rdy3", sif.tready[3], 1'b1);
            chk("stall_rdy1", sif0.tready[1], 1'b0);
            chk("stall_rdy3", sif0.tready[3], 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        sif.tvalid = '0;

        // Out-of-range select is ignored.
        frame(2, 1, 6, 1'b0, 1'b1);
        base = nacc[2];
        wait_acc(2, base + 2, 100);
        sel = 3'd5;
        run_idle(200);
        chk("oor_sel_active", sel_active, 2);
        chk("oor_locked", locked, 1'b1);
        compare("oor");
        sel = 3'd2;

        // Switch cancelled before tlast: no gap, no switch.
        chk_nobub = 1'b1;
        frame(2, 1, 8, 1'b0, 1'b1);
        base = nacc[2];
        wait_acc(2, base + 2, 100);
        sel = 3'd1;
        step();
        chk("drain_locked", locked, 1'b1);
        step();
        sel = 3'd2;
        run_idle(200);
        chk_nobub = 1'b0;
        chk("cancel_sel_active", sel_active, 2);
        chk("cancel_locked", locked, 1'b1);
        chk("cancel_done_cnt", done_cnt, 2);
        compare("cancel");

        // Reset mid-line: output valid drops at once, resync on next SOF.
        frame(2, 1, 8, 1'b0, 1'b1);
        base = nacc[2];
        wait_acc(2, base + 3, 100);
        rstn = 1'b0;
        #1;
        chk("midrst_m_tvalid", mif.tvalid, 1'b0);
        chk("midrst_locked", locked, 1'b0);
        chk("midrst_sel_active", sel_active, 0);
        chk("midrst_s_tready", sif.tready, '0);
        for (int i = 0; i < NI; i++) q[i].delete();
        vld = '0;
        sif.tvalid = '0;
        prev_fwd = 1'b0;
        prev_stall = 1'b0;
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        sel = 3'd0;
        @(negedge clk);
        rstn = 1'b1;
        push_beat(0, 1'b0, 1'b0, 1'b0);
        push_beat(0, 1'b0, 1'b0, 1'b1);
        frame(0, 1, 3, 1'b1, 1'b1);
        vld_pct = 80;
        rdy_mode = 2;
        run_idle(200);
        compare("resync");
        chk("resync_done", done_cnt, 1);
        chk("resync_locked", locked, 1'b1);
        chk("resync_sel_active", sel_active, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
